// File: rtl/alu_prog_sequencer.sv
// alu_prog_sequencer: instruction-issuing front end for the 4-bit accumulator ALU.
// Buffers host-loaded {inst, a} words in a FIFO, clears the ALU, issues one word
// per cycle, then captures the accumulator as the program result.
// Optional build macro ALU_STEP_EN adds a step_req input that gates each issue.
module alu_prog_sequencer #(
  parameter int DEPTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_inst,
  input  logic [3:0]         in_a,
  input  logic               start,
`ifdef ALU_STEP_EN
  input  logic               step_req,
`endif
  output logic               busy,
  output logic               done,
  output logic [3:0]         result,
  output logic [COUNT_W-1:0] op_count,
  output logic [1:0]         alu_inst,
  output logic [3:0]         alu_a,
  output logic               alu_reset,
  input  logic [3:0]         alu_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Program storage: {inst[1:0], a[3:0]} per entry
  logic [5:0]         mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [3:0]         result_q, result_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;

  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       issue;
  logic       step_ok;
  logic [5:0] head;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

`ifdef ALU_STEP_EN
  assign step_ok = step_req;
`else
  assign step_ok = 1'b1;
`endif

  // A word is driven to the ALU and popped in the same cycle the ALU samples it
  assign issue = (state_q == S_RUN) && !fifo_empty && step_ok;
  assign push  = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLR;
      S_CLR:   state_d = S_RUN;
      S_RUN:   if (fifo_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; HOLD drive (ADD 0) whenever nothing is issued
  always_comb begin
    busy      = (state_q == S_CLR) || (state_q == S_RUN);
    done      = (state_q == S_DONE);
    in_ready  = !fifo_full && ((state_q == S_IDLE) || (state_q == S_DONE));
    alu_reset = !RESET_N || (state_q == S_CLR);
    alu_inst  = 2'b00;
    alu_a     = 4'b0000;
    if (issue) begin
      alu_inst = head[5:4];
      alu_a    = head[3:0];
    end
  end

  // Datapath next values: FIFO pointers, result capture, saturating issue count
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, issue};
    result_d   = result_q;
    op_count_d = op_count_q;
    if ((state_q == S_RUN) && fifo_empty) begin
      // The last issued instruction has already been registered by the ALU
      result_d = alu_out;
    end
    if (state_q == S_CLR) begin
      op_count_d = '0;
    end else if (issue && (op_count_q != {COUNT_W{1'b1}})) begin
      op_count_d = op_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Datapath registers; reset discards any buffered program
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      result_q   <= '0;
      op_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      result_q   <= result_d;
      op_count_q <= op_count_d;
    end
  end

  // FIFO storage write; contents are only read when the pointers say valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_inst, in_a};
    end
  end

  assign result   = result_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_prog_sequencer.sv
// tb_alu_prog_sequencer: randomized and directed programs with a scoreboard.
// A behavioural accumulator ALU closes the loop on alu_inst/alu_a/alu_out.
module tb_alu_prog_sequencer;

  localparam int DEPTH   = 8;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [1:0]         in_inst = 2'b00;
  logic [3:0]         in_a = 4'b0000;
  logic               start = 1'b0;
  logic               step_req = 1'b0;
  logic               in_ready;
  logic               busy;
  logic               done;
  logic [3:0]         result;
  logic [COUNT_W-1:0] op_count;
  logic [1:0]         alu_inst;
  logic [3:0]         alu_a;
  logic               alu_reset;
  logic [3:0]         alu_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int res;
    int cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] iss_q[$];
  logic [5:0] pending[$];
  logic [3:0] acc = 4'd0;

  always #5 clk = ~clk;

  alu_prog_sequencer #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk(clk),
    .RESET_N(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_inst(in_inst),
    .in_a(in_a),
    .start(start),
`ifdef ALU_STEP_EN
    .step_req(step_req),
`endif
    .busy(busy),
    .done(done),
    .result(result),
    .op_count(op_count),
    .alu_inst(alu_inst),
    .alu_a(alu_a),
    .alu_reset(alu_reset),
    .alu_out(alu_out)
  );

  // Accumulator ALU semantics in plain integer arithmetic
  function automatic int alu_fn(int x, int op, int a);
    int r;
    case (op)
      0: r = (x + a) % 16;
      1: r = (x - a + 16) % 16;
      2: r = (a >= 8) ? (x >> (a - 8)) : ((x << a) % 16);
      default: r = 15 - (x ^ a);
    endcase
    return r;
  endfunction

  // Environment ALU: registered accumulator, synchronous active-high clear
  always @(posedge clk) begin
    if (alu_reset) acc <= 4'd0;
    else           acc <= 4'(alu_fn(int'(acc), int'(alu_inst), int'(alu_a)));
  end
  assign alu_out = acc;

`ifdef ALU_STEP_EN
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    step_req = (cyc % 3 == 0);
  end
`endif

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: compares issued words and completed runs against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !alu_reset && {alu_inst, alu_a} != 6'd0) begin
`ifdef ALU_STEP_EN
        check("step_gate", int'(step_req), 1);
`endif
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_extra actual=%0d required=none", {alu_inst, alu_a});
        end else begin
          check("issue_word", int'({alu_inst, alu_a}), int'(iss_q.pop_front()));
        end
      end
      if (!busy) check("hold_drive", int'({alu_inst, alu_a}), 0);
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_extra actual=1 required=0");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", int'(result), e.res);
          check("op_count", int'(op_count), e.cnt);
          check("issue_drained", iss_q.size(), 0);
          $display("run done result=%0d op_count=%0d", result, op_count);
        end
      end
    end
  end

  task automatic push(logic [5:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    {in_inst, in_a} = w;
    check("in_ready", int'(in_ready), int'(pending.size() < DEPTH));
    if (pending.size() < DEPTH) pending.push_back(w);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_prog();
    int   n;
    int   k;
    int   x;
    exp_t e;
    n = pending.size();
    x = 0;
    foreach (pending[i]) begin
      x = alu_fn(x, int'(pending[i][5:4]), int'(pending[i][3:0]));
      iss_q.push_back(pending[i]);
    end
    e.res = x;
    e.cnt = n;
    sb_q.push_back(e);
    pending.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("clr_alu_reset", int'(alu_reset), 1);
        check("clr_busy", int'(busy), 1);
      end
      if (k == 2) begin
        check("run_alu_reset", int'(alu_reset), 0);
        check("busy_in_ready", int'(in_ready), 0);
        start = 1'b1;
        in_valid = 1'b1;
        in_inst = 2'($urandom_range(0, 3));
        in_a = 4'($urandom_range(0, 15));
      end
      if (k == 3) begin
        start = 1'b0;
        in_valid = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (k > 200) begin
      check("done_timeout", k, n + 3);
      sb_q.delete();
      iss_q.delete();
    end
`ifndef ALU_STEP_EN
    else check("done_latency", k, n + 3);
`endif
  endtask

  initial begin
    int n;
    #1;
    check("rst_alu_reset", int'(alu_reset), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_op_count", int'(op_count), 0);
    check("rst_alu_word", int'({alu_inst, alu_a}), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_alu_reset", int'(alu_reset), 0);

    push({2'b00, 4'd3}); push({2'b00, 4'd5}); run_prog();
    push({2'b00, 4'd7}); push({2'b01, 4'd2}); run_prog();
    push({2'b00, 4'd3}); push({2'b10, 4'd2}); push({2'b10, 4'd9}); run_prog();
    push({2'b11, 4'd10}); run_prog();
    run_prog();

    // Overflow: ninth word must be refused and dropped
    for (int i = 0; i < 9; i++) push(6'($urandom_range(1, 63)));
    run_prog();

    // Reset in the second RUN cycle of a 4-word program
    for (int i = 0; i < 4; i++) push(6'($urandom_range(1, 63)));
    foreach (pending[i]) iss_q.push_back(pending[i]);
    pending.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_alu_reset", int'(alu_reset), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_op_count", int'(op_count), 0);
    iss_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_in_ready", int'(in_ready), 1);
    check("post_abort_busy", int'(busy), 0);
    run_prog();

    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, DEPTH);
      for (int i = 0; i < n; i++) push(6'($urandom_range(1, 63)));
      run_prog();
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
